// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester used by the FIR
// control/coefficient bus.
package apb_pkg;

  localparam int APB_ADDR_W      = 32;
  localparam int APB_DATA_W      = 32;
  localparam int APB_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter for the ACCESS phase; flags the last wait
// cycle allowed before the transfer is abandoned.
module apb_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last_wait
);

  // A LIMIT of zero disables the timeout; keep a 1-bit counter so the
  // vector never collapses to zero width.
  localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its sources, independent of block order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

  // High while the current ACCESS cycle is the LIMIT-th one; a PREADY=0
  // sample at its closing edge reaches the limit.
  assign last_wait = (LIMIT > 0) && (count == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: turns single-beat local commands into SETUP/ACCESS
// transfers, bounds PREADY waits, and reports data/error on a response port.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT_DEF
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PSLVERR
);

  apb_state_t        state, state_next;
  logic              cmd_ready_next, rsp_valid_next, rsp_err_next, rsp_timeout_next;
  logic              psel_next, penable_next, pwrite_next;
  logic [ADDR_W-1:0] paddr_next;
  logic [DATA_W-1:0] pwdata_next, rsp_rdata_next;
  logic              timer_clear, timer_en, last_wait;

  apb_wait_timer #(
    .LIMIT (TIMEOUT)
  ) u_wait_timer (
    .clk       (PCLK),
    .rst       (PRESET),
    .clear     (timer_clear),
    .enable    (timer_en),
    .last_wait (last_wait)
  );

  // All outputs are registers; the comb block computes their next values.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PADDR       <= '0;
      PSELx       <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
    end else begin
      state       <= state_next;
      cmd_ready   <= cmd_ready_next;
      rsp_valid   <= rsp_valid_next;
      rsp_rdata   <= rsp_rdata_next;
      rsp_err     <= rsp_err_next;
      rsp_timeout <= rsp_timeout_next;
      PADDR       <= paddr_next;
      PSELx       <= psel_next;
      PENABLE     <= penable_next;
      PWRITE      <= pwrite_next;
      PWDATA      <= pwdata_next;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_next       = state;
    cmd_ready_next   = 1'b0;
    rsp_valid_next   = 1'b0;
    rsp_rdata_next   = rsp_rdata;
    rsp_err_next     = rsp_err;
    rsp_timeout_next = rsp_timeout;
    paddr_next       = PADDR;
    pwrite_next      = PWRITE;
    pwdata_next      = PWDATA;
    psel_next        = 1'b0;
    penable_next     = 1'b0;
    timer_clear      = 1'b0;
    timer_en         = 1'b0;

    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          paddr_next  = cmd_addr;
          pwrite_next = cmd_write;
          pwdata_next = cmd_wdata;
          psel_next   = 1'b1;
          timer_clear = 1'b1;
          state_next  = SETUP;
        end else begin
          cmd_ready_next = 1'b1;
        end
      end

      SETUP: begin
        psel_next    = 1'b1;
        penable_next = 1'b1;
        state_next   = ACCESS;
      end

      ACCESS: begin
        timer_en = !PREADY;
        // A completer that answers on the last allowed cycle still wins.
        if (PREADY) begin
          rsp_rdata_next   = PWRITE ? '0 : PRDATA;
          rsp_err_next     = PSLVERR;
          rsp_timeout_next = 1'b0;
          rsp_valid_next   = 1'b1;
          cmd_ready_next   = 1'b1;
          state_next       = IDLE;
        end else if (last_wait) begin
          rsp_rdata_next   = '0;
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
          rsp_valid_next   = 1'b1;
          cmd_ready_next   = 1'b1;
          state_next       = IDLE;
        end else begin
          psel_next    = 1'b1;
          penable_next = 1'b1;
        end
      end

      default: begin
        cmd_ready_next = 1'b1;
        state_next     = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: zero-wait, wait states, slave error,
// timeout boundary, mid-transfer reset and back-to-back commands.
module tb_apb_master;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              PCLK, PRESET;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_err, rsp_timeout;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] PADDR;
  logic              PSELx, PENABLE, PWRITE;
  logic [DATA_W-1:0] PWDATA, PRDATA;
  logic              PREADY, PSLVERR;

  int checks = 0;
  int errors = 0;

  apb_master #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PADDR       (PADDR),
    .PSELx       (PSELx),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PREADY      (PREADY),
    .PRDATA      (PRDATA),
    .PSLVERR     (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Presents one command for its accept edge; returns at the negedge of the
  // SETUP cycle (T1) with cmd_valid dropped.
  task automatic start_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    @(negedge PCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    PRESET = 1'b1;
    repeat (2) @(negedge PCLK);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if ({PSELx, PENABLE, PWRITE} !== 3'b000) begin errors++; $display("FAIL rst_ctrl got %b exp 000", {PSELx, PENABLE, PWRITE}); end
    checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b000) begin errors++; $display("FAIL rst_rsp got %b exp 000", {rsp_valid, rsp_err, rsp_timeout}); end
    checks++; if (PADDR !== 32'h0) begin errors++; $display("FAIL rst_paddr got %h exp 0", PADDR); end
    checks++; if (PWDATA !== 32'h0) begin errors++; $display("FAIL rst_pwdata got %h exp 0", PWDATA); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rsp_rdata); end
    PRESET = 1'b0;
  endtask

  task automatic test_write_zero_wait;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0004; cmd_wdata = 32'h0000_1234;
    PREADY = 1'b1; PRDATA = 32'hFFFF_FFFF;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_t0_ready got %b exp 1", cmd_ready); end
    @(negedge PCLK); // T1
    cmd_valid = 1'b0; cmd_addr = 32'hDEAD_0000; cmd_wdata = 32'h0000_5555;
    checks++; if ({PSELx, PENABLE} !== 2'b10) begin errors++; $display("FAIL wr_t1_sel got %b exp 10", {PSELx, PENABLE}); end
    checks++; if (PADDR !== 32'h4 || PWDATA !== 32'h1234 || PWRITE !== 1'b1) begin errors++; $display("FAIL wr_t1_bus got %h/%h/%b exp 4/1234/1", PADDR, PWDATA, PWRITE); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_t1_ready got %b exp 0", cmd_ready); end
    @(negedge PCLK); // T2
    checks++; if ({PSELx, PENABLE} !== 2'b11) begin errors++; $display("FAIL wr_t2_sel got %b exp 11", {PSELx, PENABLE}); end
    checks++; if (PADDR !== 32'h4 || PWDATA !== 32'h1234) begin errors++; $display("FAIL wr_t2_bus got %h/%h exp 4/1234", PADDR, PWDATA); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_t2_rsp got %b exp 0", rsp_valid); end
    @(negedge PCLK); // T3
    PREADY = 1'b0;
    checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) begin errors++; $display("FAIL wr_t3_rsp got %b exp 100", {rsp_valid, rsp_err, rsp_timeout}); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_t3_rdata got %h exp 0", rsp_rdata); end
    checks++; if ({cmd_ready, PSELx, PENABLE} !== 3'b100) begin errors++; $display("FAIL wr_t3_idle got %b exp 100", {cmd_ready, PSELx, PENABLE}); end
    @(negedge PCLK); // T4
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_t4_pulse got %b exp 0", rsp_valid); end
  endtask

  task automatic test_read_wait;
    start_cmd(1'b0, 32'h0000_0008, 32'h0);
    PREADY = 1'b0; PRDATA = 32'h1111_1111;
    @(negedge PCLK); // T2
    checks++; if ({PSELx, PENABLE, PWRITE} !== 3'b110) begin errors++; $display("FAIL rd_t2_ctrl got %b exp 110", {PSELx, PENABLE, PWRITE}); end
    repeat (2) @(negedge PCLK); // T4
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_t4_rsp got %b exp 0", rsp_valid); end
    @(negedge PCLK); // T5
    checks++; if ({PSELx, PENABLE, rsp_valid} !== 3'b110) begin errors++; $display("FAIL rd_t5_state got %b exp 110", {PSELx, PENABLE, rsp_valid}); end
    PREADY = 1'b1; PRDATA = 32'h0000_ABCD;
    @(negedge PCLK); // T6
    PREADY = 1'b0;
    checks++; if ({rsp_valid, rsp_err} !== 2'b10) begin errors++; $display("FAIL rd_t6_rsp got %b exp 10", {rsp_valid, rsp_err}); end
    checks++; if (rsp_rdata !== 32'h0000_ABCD) begin errors++; $display("FAIL rd_t6_rdata got %h exp 0000abcd", rsp_rdata); end
  endtask

  task automatic test_slave_error;
    start_cmd(1'b0, 32'h0000_000C, 32'h0);
    PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'h0;
    repeat (2) @(negedge PCLK); // T3, one ignored PSLVERR sample behind us
    checks++; if ({PSELx, PENABLE, rsp_valid} !== 3'b110) begin errors++; $display("FAIL err_wait got %b exp 110", {PSELx, PENABLE, rsp_valid}); end
    PREADY = 1'b1; PRDATA = 32'h0000_0055;
    @(negedge PCLK); // T4
    PREADY = 1'b0; PSLVERR = 1'b0;
    checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) begin errors++; $display("FAIL err_rsp got %b exp 110", {rsp_valid, rsp_err, rsp_timeout}); end
    checks++; if (rsp_rdata !== 32'h0000_0055) begin errors++; $display("FAIL err_rdata got %h exp 00000055", rsp_rdata); end
    @(negedge PCLK);
    checks++; if ({rsp_valid, rsp_err} !== 2'b01) begin errors++; $display("FAIL err_hold got %b exp 01", {rsp_valid, rsp_err}); end
  endtask

  task automatic test_timeout;
    int bad = 0;
    start_cmd(1'b0, 32'h0000_0020, 32'h0);
    PREADY = 1'b0; PRDATA = 32'h0000_CAFE;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge PCLK);
      if ({PSELx, PENABLE, rsp_valid} !== 3'b110) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL to_access_cycles got %0d bad exp 0", bad); end
    @(negedge PCLK);
    checks++; if ({PSELx, PENABLE} !== 2'b00) begin errors++; $display("FAIL to_sel got %b exp 00", {PSELx, PENABLE}); end
    checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b111) begin errors++; $display("FAIL to_rsp got %b exp 111", {rsp_valid, rsp_err, rsp_timeout}); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata got %h exp 0", rsp_rdata); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL to_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_timeout_ready_last;
    start_cmd(1'b0, 32'h0000_0024, 32'h0);
    PREADY = 1'b0;
    repeat (TIMEOUT - 1) @(negedge PCLK);
    @(negedge PCLK); // last allowed ACCESS cycle
    checks++; if ({PSELx, PENABLE, rsp_valid} !== 3'b110) begin errors++; $display("FAIL tol_last got %b exp 110", {PSELx, PENABLE, rsp_valid}); end
    PREADY = 1'b1; PRDATA = 32'h0000_1357;
    @(negedge PCLK);
    PREADY = 1'b0;
    checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) begin errors++; $display("FAIL tol_rsp got %b exp 100", {rsp_valid, rsp_err, rsp_timeout}); end
    checks++; if (rsp_rdata !== 32'h0000_1357) begin errors++; $display("FAIL tol_rdata got %h exp 00001357", rsp_rdata); end
  endtask

  task automatic test_reset_mid;
    start_cmd(1'b1, 32'h0000_0030, 32'h0000_0077);
    PREADY = 1'b0;
    @(negedge PCLK); // T2
    checks++; if ({PSELx, PENABLE} !== 2'b11) begin errors++; $display("FAIL rm_access got %b exp 11", {PSELx, PENABLE}); end
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0; PREADY = 1'b1;
    checks++; if ({PSELx, PENABLE, rsp_valid} !== 3'b000) begin errors++; $display("FAIL rm_drop got %b exp 000", {PSELx, PENABLE, rsp_valid}); end
    checks++; if (PADDR !== 32'h0) begin errors++; $display("FAIL rm_paddr got %h exp 0", PADDR); end
    @(negedge PCLK);
    PREADY = 1'b0;
    checks++; if ({cmd_ready, rsp_valid, PSELx} !== 3'b100) begin errors++; $display("FAIL rm_after got %b exp 100", {cmd_ready, rsp_valid, PSELx}); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_addr, exp_data;
    int j, ph;
    PREADY = 1'b1;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'hA0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge PCLK);
      j  = (k - 1) / 3;
      ph = (k - 1) % 3;
      exp_addr = 32'h40 + 32'(4 * j);
      exp_data = 32'hA0 + 32'(j);
      if (ph == 0) begin
        checks++; if ({PSELx, PENABLE, rsp_valid} !== 3'b100) begin errors++; $display("FAIL b2b_setup%0d got %b exp 100", j, {PSELx, PENABLE, rsp_valid}); end
        checks++; if (PADDR !== exp_addr || PWDATA !== exp_data) begin errors++; $display("FAIL b2b_bus%0d got %h/%h exp %h/%h", j, PADDR, PWDATA, exp_addr, exp_data); end
      end else if (ph == 1) begin
        checks++; if ({PSELx, PENABLE, rsp_valid} !== 3'b110) begin errors++; $display("FAIL b2b_access%0d got %b exp 110", j, {PSELx, PENABLE, rsp_valid}); end
        checks++; if (PADDR !== exp_addr) begin errors++; $display("FAIL b2b_hold%0d got %h exp %h", j, PADDR, exp_addr); end
      end else begin
        checks++; if ({cmd_ready, rsp_valid, PSELx} !== 3'b110) begin errors++; $display("FAIL b2b_rsp%0d got %b exp 110", j, {cmd_ready, rsp_valid, PSELx}); end
      end
      if (j + 1 <= 3) begin
        cmd_addr  = 32'h40 + 32'(4 * (j + 1));
        cmd_wdata = 32'hA0 + 32'(j + 1);
      end else begin
        cmd_valid = 1'b0;
      end
    end
    @(negedge PCLK);
    PREADY = 1'b0;
    checks++; if ({PSELx, rsp_valid, cmd_ready} !== 3'b001) begin errors++; $display("FAIL b2b_end got %b exp 001", {PSELx, rsp_valid, cmd_ready}); end
  endtask

  initial begin
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slave_error();
    test_timeout();
    test_timeout_ready_last();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
